fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the queue capacity in instruction pairs; legal values are powers of two, at least 2.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  synchronous active-low reset.
REQ-005 Port: p0_IM_maddr  out  9  instruction memory address for the even slot.
REQ-006 Port: p1_IM_maddr  out  9  instruction memory address for the odd slot.
REQ-007 Port: p0_IM_rdata  in  16  even-slot instruction, valid one cycle after its address.
REQ-008 Port: p1_IM_rdata  in  16  odd-slot instruction, valid one cycle after its address.
REQ-009 Port: fetch_next  in  1  consumer accepts the head pair this cycle.
REQ-010 Port: redirect  in  1  branch redirect; flush the queue and refetch.
REQ-011 Port: redirect_pc  in  9  redirect target address.
REQ-012 Port: pair_valid  out  1  head pair is present.
REQ-013 Port: p0_IR_out / p1_IR_out  out  16 each  head pair instructions.
REQ-014 Port: p0_PC_out / p1_PC_out  out  8 each  head pair addresses.

Function
REQ-015 The internal fetch_pc (9 bits, bit 8 always 0) SHALL drive p0_IM_maddr={1'b0,fetch_pc[7:1],1'b0} and p1_IM_maddr={1'b0,fetch_pc[7:1],1'b1} every cycle.
REQ-016 A fetch SHALL issue in a cycle when count+inflight<DEPTH and redirect=0; it sets inflight=1 for the next cycle and advances fetch_pc[7:1] by 1, wrapping 8'hFE to 8'h00.
REQ-017 The pair returned in the cycle after an issue SHALL be pushed at the end of that cycle unless it was killed by a redirect.
REQ-018 The head pair SHALL be popped when fetch_next=1 and pair_valid=1; fetch_next with pair_valid=0 SHALL be ignored.
REQ-019 A simultaneous push and pop SHALL leave count unchanged; count never exceeds DEPTH and never underflows.
REQ-020 pair_valid SHALL equal (count!=0); when count=0, IR and PC outputs SHALL be 0.
REQ-021 p0_PC_out SHALL be the stored even address[7:0], and p1_PC_out SHALL be p0_PC_out+1.
REQ-022 On redirect=1, at the clock edge: count=0, any in-flight pair killed, fetch_pc=redirect_pc aligned per REQ-029/030, and no issue that cycle.
REQ-023 A redirect SHALL win over a simultaneous fetch_next or push.
REQ-024 Latency: an issue in cycle t SHALL give pair_valid in cycle t+2 when the queue was empty.
REQ-025 Steady-state throughput SHALL be one pair per cycle with fetch_next held high.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL set fetch_pc=0, count=0, inflight=0 and clear the kill state.
REQ-027 Outputs during and after reset SHALL be: pair_valid=0, IR/PC outputs 0, maddr 0/1.
REQ-028 Reset asserted mid-operation SHALL discard queued and in-flight pairs, and the first fetch after release SHALL be address 0.

Configuration
REQ-029 With FETCHQ_ODD_ENTRY_EN defined, a redirect to an odd redirect_pc SHALL mark the first pushed pair so that its p0_IR_out reads as the package NOP constant; p1 is unaffected.
REQ-030 Without FETCHQ_ODD_ENTRY_EN, redirect_pc[0] SHALL be ignored (aligned down), and no slot is ever replaced by NOP.

Structure
REQ-031 Package kl_fetch_pkg SHALL hold the NOP constant (16'h0000), the pair typedef {ir0, ir1, pc[7:0], kill0} and the PC width constant.
REQ-032 Storage SHALL be a sub-module fetchq_fifo (DEPTH-entry circular buffer with push, pop and flush, and wrapping head/tail pointers); fetch control stays in fetch_queue.

Verification
REQ-033 Reset release, fetch_next=1, IM returns addr-tagged data -> pair_valid first high in 2nd cycle; PC_out 0/1, then 2/3, 4/5 each cycle.
REQ-034 fetch_next=0 for 10 cycles -> count saturates at DEPTH=4, maddr holds at 8, no pair lost; resume -> PCs 0..7 in order.
REQ-035 Redirect to 9'h040 with 2 pairs queued and 1 in flight -> next cycle pair_valid=0; first PC_out=8'h40, and the stale pairs never appear.
REQ-036 fetch_pc 8'hFE -> after pair FE/FF, the next fetch is address 0 (wrap), with bit 8 of maddr always 0.
REQ-037 Redirect to 9'h013 -> with macro: PC_out 12/13, p0_IR_out=0; without macro: p0_IR_out=IM[12].
REQ-038 rst=0 asserted while full and fetch_next=1 -> all outputs 0 the next cycle; after release the fetch restarts at 0.

Source files
------------

// File: rtl/kl_fetch_pkg.sv
// Shared types and constants for the paired-instruction fetch queue.
// Holds the NOP encoding, the stored-pair payload and the address widths.
package kl_fetch_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned IR_W    = 16;
    localparam int unsigned MADDR_W = 9;

    localparam logic [IR_W-1:0] NOP = 16'h0000;

    // One queue entry: both slot instructions, the even address, and a flag
    // that blanks the even slot when a redirect entered on an odd address.
    typedef struct packed {
        logic [IR_W-1:0] ir0;
        logic [IR_W-1:0] ir1;
        logic [PC_W-1:0] pc;
        logic            kill0;
    } fetch_pair_t;

    // Instruction memory address for one slot of the pair at pc[7:1].
    function automatic logic [MADDR_W-1:0] slot_addr(input logic [PC_W-2:0] hi,
                                                      input logic            odd);
        return {1'b0, hi, odd};
    endfunction

endpackage

// File: rtl/fetchq_fifo.sv
// Circular buffer of fetched instruction pairs.
// Ports:
//   clk      - clock
//   i_rst_n  - synchronous active-low reset
//   i_push   - write i_wdata at the tail
//   i_pop    - release the head entry (ignored when empty)
//   i_flush  - discard all entries; wins over push and pop
//   i_wdata  - pair to store
//   o_head   - head entry, all zero when empty
//   o_valid  - at least one entry stored
//   o_count  - number of stored entries
module fetchq_fifo
    import kl_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_pair_t              i_wdata,
    output fetch_pair_t              o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_pair_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Payload storage needs no reset; the head is gated by o_valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_head  = o_valid ? r_mem[r_head] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Paired instruction fetch queue: issues even/odd instruction memory reads,
// buffers the returned pairs and presents the head pair to the consumer.
// Optional build macro FETCHQ_ODD_ENTRY_EN: a redirect to an odd address
// blanks the even slot of the first pair fetched afterwards with NOP.
// Ports:
//   clk                      - clock
//   rst                      - synchronous active-low reset
//   p0_IM_maddr/p1_IM_maddr  - even/odd instruction memory address
//   p0_IM_rdata/p1_IM_rdata  - even/odd instruction, one cycle after address
//   fetch_next               - consumer takes the head pair
//   redirect, redirect_pc    - flush and refetch from redirect_pc
//   pair_valid               - head pair present
//   p0_IR_out/p1_IR_out      - head pair instructions
//   p0_PC_out/p1_PC_out      - head pair addresses
module fetch_queue
    import kl_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [MADDR_W-1:0] p0_IM_maddr,
    output logic [MADDR_W-1:0] p1_IM_maddr,
    input  logic [IR_W-1:0]    p0_IM_rdata,
    input  logic [IR_W-1:0]    p1_IM_rdata,
    input  logic               fetch_next,
    input  logic               redirect,
    input  logic [MADDR_W-1:0] redirect_pc,
    output logic               pair_valid,
    output logic [IR_W-1:0]    p0_IR_out,
    output logic [IR_W-1:0]    p1_IR_out,
    output logic [PC_W-1:0]    p0_PC_out,
    output logic [PC_W-1:0]    p1_PC_out
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned HI_W  = PC_W - 1;

    logic [HI_W-1:0]  r_fetch_hi;
    logic             r_inflight;
    logic [HI_W-1:0]  r_inflight_hi;
    logic             r_inflight_kill0;
    logic             r_kill0_pend;

    logic [CNT_W-1:0] w_count;
    logic             w_valid;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_kill0_on_redirect;
    fetch_pair_t      w_wdata;
    fetch_pair_t      w_head;
    logic             w_unused;

`ifdef FETCHQ_ODD_ENTRY_EN
    assign w_kill0_on_redirect = redirect_pc[0];
`else
    assign w_kill0_on_redirect = 1'b0;
`endif

    // Bit 8 of the address space is never fetched; bit 0 is only a hint.
    assign w_unused = ^{redirect_pc[MADDR_W-1], redirect_pc[0]};

    // Reserve a slot for the in-flight pair so a return always has room.
    assign w_issue = !redirect &&
                     ((SUM_W'(w_count) + SUM_W'(r_inflight)) < SUM_W'(DEPTH));
    assign w_push  = r_inflight && !redirect;
    assign w_pop   = fetch_next && !redirect;

    assign w_wdata.ir0   = p0_IM_rdata;
    assign w_wdata.ir1   = p1_IM_rdata;
    assign w_wdata.pc    = {r_inflight_hi, 1'b0};
    assign w_wdata.kill0 = r_inflight_kill0;

    fetchq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    // Fetch address, in-flight tracking and pending odd-entry blanking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_hi       <= '0;
            r_inflight       <= 1'b0;
            r_inflight_hi    <= '0;
            r_inflight_kill0 <= 1'b0;
            r_kill0_pend     <= 1'b0;
        end else if (redirect) begin
            r_fetch_hi       <= redirect_pc[PC_W-1:1];
            r_inflight       <= 1'b0;
            r_inflight_kill0 <= 1'b0;
            r_kill0_pend     <= w_kill0_on_redirect;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_hi    <= r_fetch_hi;
                r_inflight_kill0 <= r_kill0_pend;
                r_kill0_pend     <= 1'b0;
                r_fetch_hi       <= r_fetch_hi + HI_W'(1);
            end
        end
    end

    assign p0_IM_maddr = slot_addr(r_fetch_hi, 1'b0);
    assign p1_IM_maddr = slot_addr(r_fetch_hi, 1'b1);

    // Empty head reads as all zero, so kill0 and pc are zero then too.
    assign pair_valid = w_valid;
    assign p0_IR_out  = w_head.kill0 ? NOP : w_head.ir0;
    assign p1_IR_out  = w_head.ir1;
    assign p0_PC_out  = w_head.pc;
    assign p1_PC_out  = w_valid ? (w_head.pc + PC_W'(1)) : '0;

endmodule
